// File: rtl/burst_arbiter_if.sv
// rtl/burst_arbiter_if.sv - Avalon-MM burst port bundle shared by masters and the slave
interface burst_arbiter_if #(parameter int ADDR = 32);
    logic [ADDR-1:0] addr;
    logic            write;
    logic [31:0]     writedata;
    logic            read;
    logic [3:0]      byteenable;
    logic [2:0]      burstcount;
    logic [31:0]     readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport master (
        output addr, write, writedata, read, byteenable, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  addr, write, writedata, read, byteenable, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/burst_arbiter.sv
// rtl/burst_arbiter.sv - two-master Avalon-MM burst arbiter, whole-burst grants
// Define BURST_ARB_ROUND_RR_EN for round-robin; otherwise m0 has fixed priority.
module burst_arbiter #(
    parameter int ADDR = 32
) (
    input  logic             clk_sys,
    input  logic             rst,
    burst_arbiter_if.slave   m0,
    burst_arbiter_if.slave   m1,
    burst_arbiter_if.master  s
);
    typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_DATA} state_t;

    state_t     state, state_nx;
    logic       grant, grant_nx;
    logic       last_grant, last_grant_nx;
    logic [2:0] beats, beats_nx;
    logic [2:0] len, len_nx;

    logic            req0, req1, pick;
    logic            p_write;
    logic [2:0]      p_bc;
    logic [ADDR-1:0] g_addr;
    logic            g_write, g_read;
    logic [31:0]     g_writedata;
    logic [3:0]      g_be;
    logic            last_beat;

    assign req0 = m0.write | m0.read;
    assign req1 = m1.write | m1.read;

    always_comb begin
        pick = !req0;
`ifdef BURST_ARB_ROUND_RR_EN
        if (req0 && req1)
            pick = ~last_grant;
`endif
    end

    assign p_write     = pick  ? m1.write      : m0.write;
    assign p_bc        = pick  ? m1.burstcount : m0.burstcount;
    assign g_addr      = grant ? m1.addr       : m0.addr;
    assign g_write     = grant ? m1.write      : m0.write;
    assign g_read      = grant ? m1.read       : m0.read;
    assign g_writedata = grant ? m1.writedata  : m0.writedata;
    assign g_be        = grant ? m1.byteenable : m0.byteenable;
    assign last_beat   = (beats == len - 3'd1);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beats      <= 3'd0;
            len        <= 3'd0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            beats      <= beats_nx;
            len        <= len_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        beats_nx      = beats;
        len_nx        = len;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_nx = pick;
                    len_nx   = (p_bc == 3'd0) ? 3'd1 : p_bc;
                    beats_nx = 3'd0;
                    state_nx = p_write ? WRITE : READ_CMD;
                end
            end
            WRITE: begin
                // A master that drops write mid-burst simply stalls the burst.
                if (g_write && !s.waitrequest) begin
                    beats_nx = beats + 3'd1;
                    if (last_beat) begin
                        state_nx      = IDLE;
                        last_grant_nx = grant;
                    end
                end
            end
            READ_CMD: begin
                if (g_read && !s.waitrequest) begin
                    state_nx = READ_DATA;
                    beats_nx = 3'd0;
                end
            end
            READ_DATA: begin
                if (s.readdatavalid) begin
                    beats_nx = beats + 3'd1;
                    if (last_beat) begin
                        state_nx      = IDLE;
                        last_grant_nx = grant;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m0.readdata = s.readdata;
    assign m1.readdata = s.readdata;

    always_comb begin
        s.addr           = '0;
        s.write          = 1'b0;
        s.writedata      = 32'd0;
        s.read           = 1'b0;
        s.byteenable     = 4'd0;
        s.burstcount     = 3'd0;
        m0.waitrequest   = 1'b1;
        m1.waitrequest   = 1'b1;
        m0.readdatavalid = 1'b0;
        m1.readdatavalid = 1'b0;
        case (state)
            WRITE: begin
                s.addr       = g_addr;
                s.write      = g_write;
                s.writedata  = g_writedata;
                s.byteenable = g_be;
                s.burstcount = len;
                if (grant) m1.waitrequest = s.waitrequest;
                else       m0.waitrequest = s.waitrequest;
            end
            READ_CMD: begin
                s.addr       = g_addr;
                s.read       = g_read;
                s.byteenable = g_be;
                s.burstcount = len;
                if (grant) m1.waitrequest = s.waitrequest;
                else       m0.waitrequest = s.waitrequest;
            end
            READ_DATA: begin
                if (grant) m1.readdatavalid = s.readdatavalid;
                else       m0.readdatavalid = s.readdatavalid;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_burst_arbiter.sv
// tb/tb_burst_arbiter.sv - directed scoreboard bench for burst_arbiter
module tb_burst_arbiter;
`ifdef BURST_ARB_ROUND_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_count = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    logic model_last = 1'b1;

    logic [70:0] wr_q[$];
    logic [34:0] rc_q[$];
    logic [32:0] rd_q[$];

    burst_arbiter_if m0_if();
    burst_arbiter_if m1_if();
    burst_arbiter_if s_if();

    burst_arbiter dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave-side monitor: every accepted command and forwarded read beat is scored.
    always @(negedge clk_sys) begin
        logic [70:0] we;
        logic [34:0] ce;
        logic [32:0] de;
        if (s_if.write && !s_if.waitrequest) begin
            acc_count++;
            prev_acc = last_acc;
            last_acc = cyc;
            check("wr_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
                we = wr_q.pop_front();
                check("wr_beat", {s_if.addr, s_if.writedata, s_if.byteenable, s_if.burstcount}, we);
            end
        end
        if (s_if.read && !s_if.waitrequest) begin
            check("rc_expected", rc_q.size() != 0, 1);
            if (rc_q.size() != 0) begin
                ce = rc_q.pop_front();
                check("rd_cmd", {s_if.addr, s_if.burstcount}, ce);
            end
        end
        if (m0_if.readdatavalid || m1_if.readdatavalid) begin
            check("rdv_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
                de = rd_q.pop_front();
                check("rdv_route", {m1_if.readdatavalid, m0_if.readdatavalid}, de[32] ? 2'b10 : 2'b01);
                check("rd_data", de[32] ? m1_if.readdata : m0_if.readdata, de[31:0]);
            end
        end
    end

    task automatic drive_m(input int m, input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input logic [2:0] bc);
        if (m == 0) begin
            m0_if.write = wr; m0_if.read = rd; m0_if.addr = a;
            m0_if.writedata = d; m0_if.byteenable = be; m0_if.burstcount = bc;
        end else begin
            m1_if.write = wr; m1_if.read = rd; m1_if.addr = a;
            m1_if.writedata = d; m1_if.byteenable = be; m1_if.burstcount = bc;
        end
    endtask

    task automatic wait_accept(input int m);
        int   n = 0;
        logic w;
        do begin
            @(negedge clk_sys);
            w = (m == 0) ? m0_if.waitrequest : m1_if.waitrequest;
            @(posedge clk_sys); #1;
            n++;
        end while (w && n < 100);
        check("accept_within_budget", w, 1'b0);
    endtask

    function automatic void push_wr(input logic [31:0] a, input int n, input logic [31:0] d0,
                                    input logic [3:0] be);
        logic [2:0] bc;
        bc = (n == 0) ? 3'd1 : 3'(n);
        for (int i = 0; i < int'(bc); i++)
            wr_q.push_back({a, d0 + 32'(i), be, bc});
    endfunction

    task automatic m_write(input int m, input logic [31:0] a, input int n, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            drive_m(m, 1'b1, 1'b0, a, d0 + 32'(i), 4'hF, 3'(n));
            wait_accept(m);
        end
        drive_m(m, 1'b0, 1'b0, a, 32'd0, 4'hF, 3'(n));
    endtask

    task automatic m_read(input int m, input logic [31:0] a, input int n);
        rc_q.push_back({a, 3'(n)});
        drive_m(m, 1'b0, 1'b1, a, 32'd0, 4'hF, 3'(n));
        wait_accept(m);
        drive_m(m, 1'b0, 1'b0, a, 32'd0, 4'hF, 3'(n));
    endtask

    task automatic s_beat(input logic [31:0] d);
        s_if.readdatavalid = 1'b1;
        s_if.readdata = d;
        @(posedge clk_sys); #1;
        s_if.readdatavalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        logic       first;
        int         a0;
        pat = 10'b0011101110;
        drive_m(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        s_if.waitrequest = 1'b0;
        s_if.readdata = 32'd0;
        s_if.readdatavalid = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 rst = 1'b0;

        @(negedge clk_sys);
        check("rst_s_write", s_if.write, 0);
        check("rst_s_read", s_if.read, 0);
        check("rst_s_addr", s_if.addr, 0);
        check("rst_s_bc", s_if.burstcount, 0);
        check("rst_m0_wait", m0_if.waitrequest, 1);
        check("rst_m1_wait", m1_if.waitrequest, 1);
        check("rst_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 0);

        // m0 write burst of 4 at 0x100 with no slave stalls.
        @(posedge clk_sys); #1;
        push_wr(32'h100, 4, 32'hA0, 4'hF);
        drive_m(0, 1'b1, 1'b0, 32'h100, 32'hA0, 4'hF, 3'd4);
        @(negedge clk_sys);
        check("t1_arb_latency", s_if.write, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            check("t1_s_write", s_if.write, 1);
            check("t1_s_bc", s_if.burstcount, 4);
            check("t1_s_addr", s_if.addr, 32'h100);
            check("t1_m1_wait", m1_if.waitrequest, 1);
            @(posedge clk_sys); #1;
            if (k < 3) m0_if.writedata = 32'hA0 + 32'(k + 1);
            else       m0_if.write = 1'b0;
        end
        @(negedge clk_sys);
        check("t1_idle_write", s_if.write, 0);
        check("t1_idle_m0_wait", m0_if.waitrequest, 1);
        model_last = 1'b0;
        @(posedge clk_sys); #1;

        // m1 read burst of 3 at 0x40, beats separated by 2-cycle gaps.
        m_read(1, 32'h40, 3);
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(posedge clk_sys);
            #1;
            rd_q.push_back({1'b1, 32'hB000 + 32'(k)});
            s_beat(32'hB000 + 32'(k));
        end
        model_last = 1'b1;
        check("t2_rd_drained", rd_q.size(), 0);
        check("t2_rc_drained", rc_q.size(), 0);

        // Contention: single m0 write first so round-robin has a history to act on.
        push_wr(32'h10, 1, 32'hC100, 4'hF);
        m_write(0, 32'h10, 1, 32'hC100);
        model_last = 1'b0;
        for (int r = 0; r < 4; r++) begin
            first = RR_EN ? ~model_last : 1'b0;
            a0 = 16'h2000 + r * 16;
            if (first == 1'b0) begin
                push_wr(32'(a0), 1, 32'hD000 + 32'(r), 4'hF);
                push_wr(32'(a0 + 4), 1, 32'hE000 + 32'(r), 4'hF);
            end else begin
                push_wr(32'(a0 + 4), 1, 32'hE000 + 32'(r), 4'hF);
                push_wr(32'(a0), 1, 32'hD000 + 32'(r), 4'hF);
            end
            fork
                m_write(0, 32'(a0), 1, 32'hD000 + 32'(r));
                m_write(1, 32'(a0 + 4), 1, 32'hE000 + 32'(r));
            join
            model_last = ~first;
            check("cont_turnaround", last_acc - prev_acc, 2);
        end
        check("cont_wr_drained", wr_q.size(), 0);

        // Write burst 4 with slave stalls of 3 cycles on beats 2 and 3.
        a0 = acc_count;
        push_wr(32'h300, 4, 32'hF0, 4'hF);
        fork
            m_write(0, 32'h300, 4, 32'hF0);
            begin
                @(posedge clk_sys); #1;
                for (int c = 0; c < 10; c++) begin
                    s_if.waitrequest = pat[c];
                    @(negedge clk_sys);
                    check("t4_m0_wait_mirror", m0_if.waitrequest, pat[c]);
                    @(posedge clk_sys); #1;
                end
                s_if.waitrequest = 1'b0;
            end
        join
        check("t4_accepted_beats", acc_count - a0, 4);
        model_last = 1'b0;

        // Reset during READ_DATA after one of four beats.
        m_read(0, 32'h400, 4);
        rd_q.push_back({1'b0, 32'h5100});
        s_beat(32'h5100);
        rst = 1'b1;
        @(posedge clk_sys); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_if.readdatavalid = 1'b1;
            s_if.readdata = 32'h5101 + 32'(k);
            @(negedge clk_sys);
            check("t5_m0_wait", m0_if.waitrequest, 1);
            check("t5_m1_wait", m1_if.waitrequest, 1);
            check("t5_s_read", s_if.read, 0);
            check("t5_dropped", m0_if.readdatavalid, 0);
            @(posedge clk_sys); #1;
        end
        s_if.readdatavalid = 1'b0;
        model_last = 1'b1;

        // Read and write together with burstcount 0: one write beat, then the read.
        push_wr(32'h200, 0, 32'h77, 4'h3);
        drive_m(0, 1'b1, 1'b1, 32'h200, 32'h77, 4'h3, 3'd0);
        wait_accept(0);
        drive_m(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'h3, 3'd0);
        rc_q.push_back({32'h200, 3'd1});
        @(negedge clk_sys);
        check("t6_turnaround_read", s_if.read, 0);
        check("t6_turnaround_wait", m0_if.waitrequest, 1);
        wait_accept(0);
        drive_m(0, 1'b0, 1'b0, 32'h200, 32'h0, 4'h3, 3'd0);
        rd_q.push_back({1'b0, 32'h6600});
        s_beat(32'h6600);
        @(negedge clk_sys);
        check("end_wr_drained", wr_q.size(), 0);
        check("end_rc_drained", rc_q.size(), 0);
        check("end_rd_drained", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
